// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding and word widths for the serializer arbiter
package ser_pkg;

    localparam int DATA_W = 16;
    localparam int MOD_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last grant
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] win,
    output logic         valid
);

    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int off);
        return W'((int'(base) + off) % N);
    endfunction

    always_comb begin
        win   = '0;
        valid = 1'b0;
        // Farthest offset first, so the nearest requester after last overwrites and wins.
        for (int k = N; k >= 1; k--) begin
            if (req[wrap_idx(last, k)]) begin
                win   = wrap_idx(last, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_arb.sv
// rtl/ser_arb.sv - round-robin arbiter feeding one parallel word at a time to a serializer
module ser_arb
    import ser_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int BUSY_TO = 4,
    localparam int GW      = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ*MOD_W-1:0]    req_mod_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [MOD_W-1:0]          data_mod_o,
    output logic                      data_val_o,
    input  logic                      busy_i,
    output logic [GW-1:0]             grant_id_o,
    output logic                      arb_busy_o
);

    localparam int CW = $clog2(BUSY_TO + 1);

    arb_state_t          state_q, state_n;
    logic [DATA_W-1:0]   data_q;
    logic [MOD_W-1:0]    mod_q;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       last_q;
    logic [CW-1:0]       cnt_q;
    logic [GW-1:0]       pick_win;
    logic                pick_valid;
    logic                start;
    logic                timeout;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req   (req_i),
        .last  (last_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    assign start   = (state_q == ST_IDLE) && pick_valid && !busy_i;
    assign timeout = (cnt_q == CW'(BUSY_TO - 1));

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_n = ST_ISSUE;
            ST_ISSUE:     state_n = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (busy_i)       state_n = ST_WAIT_DONE;
                else if (timeout) state_n = ST_IDLE;
            end
            ST_WAIT_DONE: if (!busy_i) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mod_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            // Capture the winner's word at selection; later input changes are ignored.
            if (start) begin
                data_q  <= req_data_i[int'(pick_win)*DATA_W +: DATA_W];
                mod_q   <= req_mod_i[int'(pick_win)*MOD_W +: MOD_W];
                grant_q <= pick_win;
            end
            if (state_q == ST_ISSUE) last_q <= grant_q;
            if (state_q == ST_WAIT_BUSY && !busy_i) cnt_q <= cnt_q + CW'(1);
            else                                    cnt_q <= '0;
        end
    end

    // Strobes are masked during reset so a reset landing on ISSUE cannot leak a pulse.
    assign data_val_o = (state_q == ST_ISSUE) && !srst_i;
    assign ack_o      = data_val_o ? (N_REQ'(1) << grant_q) : '0;
    assign arb_busy_o = (state_q != ST_IDLE) && !srst_i;
    assign data_o     = data_q;
    assign data_mod_o = mod_q;
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_ser_arb.sv
// tb/tb_ser_arb.sv - self-checking bench for ser_arb with a round-robin reference model
module tb_ser_arb;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [15:0] req_mod;
    logic [3:0]  ack;
    logic [15:0] dout;
    logic [3:0]  dmod;
    logic        dval;
    logic        busy;
    logic [1:0]  grant;
    logic        arb_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ser_arb #(
        .N_REQ   (4),
        .BUSY_TO (4)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .req_i      (req),
        .req_data_i (req_data),
        .req_mod_i  (req_mod),
        .ack_o      (ack),
        .data_o     (dout),
        .data_mod_o (dmod),
        .data_val_o (dval),
        .busy_i     (busy),
        .grant_id_o (grant),
        .arb_busy_o (arb_busy)
    );

    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        req  = '0;
        busy = 1'b0;
        step();
        step();
        srst = 1'b0;
    endtask

    task automatic wait_val(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (dval) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        int n;
        srst = 1'b1; req = 4'hF; busy = 1'b0; req_data = 64'h1234_5678_9ABC_DEF0; req_mod = 16'hFFFF;
        step();
        checks++; if (ack !== 4'b0 || dval !== 1'b0) begin errors++; $display("FAIL reset_strobe: ack=%b val=%b want 0", ack, dval); end
        step();
        checks++; if (dout !== 16'h0 || dmod !== 4'h0) begin errors++; $display("FAIL reset_data: data=%h mod=%h want 0", dout, dmod); end
        checks++; if (grant !== 2'd0 || arb_busy !== 1'b0) begin errors++; $display("FAIL reset_state: grant=%0d arb_busy=%b want 0", grant, arb_busy); end
        srst = 1'b0;
        wait_val(4, seen, n);
        checks++; if (!seen || n != 1 || grant !== 2'd0 || ack !== 4'b0001) begin
            errors++; $display("FAIL reset_first_prio: seen=%b n=%0d grant=%0d ack=%b want 1 1 0 0001", seen, n, grant, ack);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit seen;
        int n;
        do_reset();
        req_data[2*16 +: 16] = 16'hA5C3;
        req_mod[2*4 +: 4]    = 4'h0;
        req = 4'b0100;
        wait_val(10, seen, n);
        checks++; if (!seen) begin errors++; $display("FAIL single_issue: no data_val within 10 cycles"); end
        checks++; if (ack !== 4'b0100 || grant !== 2'd2) begin errors++; $display("FAIL single_ack: ack=%b grant=%0d want 0100 2", ack, grant); end
        checks++; if (dout !== 16'hA5C3 || dmod !== 4'h0) begin errors++; $display("FAIL single_data: data=%h mod=%h want a5c3 0", dout, dmod); end
        req = 4'b0; busy = 1'b1;
        step();
        checks++; if (ack !== 4'b0 || dval !== 1'b0) begin errors++; $display("FAIL single_pulse: ack=%b val=%b want 0 0", ack, dval); end
        step();
        busy = 1'b0;
        step();
        checks++; if (arb_busy !== 1'b0 || grant !== 2'd2 || dout !== 16'hA5C3) begin
            errors++; $display("FAIL single_idle: arb_busy=%b grant=%0d data=%h want 0 2 a5c3", arb_busy, grant, dout);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        int n, exp, last;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[i*16 +: 16] = 16'h1000 * 16'(i + 1) + 16'(i);
            req_mod[i*4 +: 4]    = 4'(i + 5);
        end
        last = 3;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_val(12, seen, n);
            exp = model_pick(req, last);
            checks++; if (!seen || n != ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_timing%0d: seen=%b n=%0d", k, seen, n); end
            checks++; if (grant !== 2'(exp) || ack !== (4'b1 << exp)) begin
                errors++; $display("FAIL rr_grant%0d: grant=%0d ack=%b want %0d", k, grant, ack, exp);
            end
            checks++; if (dout !== req_data[exp*16 +: 16] || dmod !== req_mod[exp*4 +: 4]) begin
                errors++; $display("FAIL rr_data%0d: data=%h mod=%h want %h %h", k, dout, dmod, req_data[exp*16 +: 16], req_mod[exp*4 +: 4]);
            end
            last = exp;
            busy = 1'b1;
            step();
            step();
            busy = 1'b0;
        end
        req = 4'b0;
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        do_reset();
        req_data[0 +: 16]  = 16'h0F0F; req_mod[0 +: 4] = 4'h1;
        req_data[16 +: 16] = 16'hBEEF; req_mod[4 +: 4] = 4'h1;
        req = 4'b0011;
        wait_val(6, seen, n);
        checks++; if (!seen || grant !== 2'd0) begin errors++; $display("FAIL to_first: seen=%b grant=%0d want 1 0", seen, grant); end
        req[0] = 1'b0;
        wait_val(20, seen, n);
        checks++; if (!seen || n != 6) begin errors++; $display("FAIL to_spacing: seen=%b cycles=%0d want 6", seen, n); end
        checks++; if (grant !== 2'd1 || ack !== 4'b0010 || dout !== 16'hBEEF) begin
            errors++; $display("FAIL to_next: grant=%0d ack=%b data=%h want 1 0010 beef", grant, ack, dout);
        end
        req = 4'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        do_reset();
        req_data[16 +: 16] = 16'h7777;
        req_mod[4 +: 4]    = 4'h9;
        req = 4'b0010;
        wait_val(6, seen, n);
        req = 4'b0; busy = 1'b1;
        step();
        step();
        checks++; if (arb_busy !== 1'b1 || grant !== 2'd1) begin errors++; $display("FAIL rm_pre: arb_busy=%b grant=%0d want 1 1", arb_busy, grant); end
        srst = 1'b1;
        step();
        checks++; if (ack !== 4'b0 || dval !== 1'b0 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL rm_strobes: ack=%b val=%b arb_busy=%b want 0", ack, dval, arb_busy);
        end
        checks++; if (dout !== 16'h0 || dmod !== 4'h0 || grant !== 2'd0) begin
            errors++; $display("FAIL rm_clear: data=%h mod=%h grant=%0d want 0", dout, dmod, grant);
        end
        srst = 1'b0; busy = 1'b0; req = 4'hF;
        wait_val(5, seen, n);
        checks++; if (!seen || n != 1 || grant !== 2'd0 || ack !== 4'b0001) begin
            errors++; $display("FAIL rm_regrant: seen=%b n=%0d grant=%0d ack=%b want 1 1 0 0001", seen, n, grant, ack);
        end
        req = 4'b0;
    endtask

    task automatic test_hold_data();
        bit seen;
        int n;
        do_reset();
        req_data[16 +: 16] = 16'h1111;
        req = 4'b0010;
        wait_val(6, seen, n);
        checks++; if (!seen || dout !== 16'h1111) begin errors++; $display("FAIL hold_issue: seen=%b data=%h want 1 1111", seen, dout); end
        req = 4'b0; busy = 1'b1;
        step();
        step();
        req_data[16 +: 16] = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL hold_busy%0d: data=%h want 1111", i, dout); end
        end
        busy = 1'b0;
        step();
        step();
        checks++; if (dout !== 16'h1111 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle: data=%h arb_busy=%b want 1111 0", dout, arb_busy);
        end
    endtask

    task automatic test_busy_block();
        do_reset();
        busy = 1'b1;
        req  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (ack !== 4'b0 || dval !== 1'b0) begin errors++; $display("FAIL bb_blocked%0d: ack=%b val=%b want 0 0", i, ack, dval); end
        end
        busy = 1'b0;
        step();
        checks++; if (dval !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL bb_release: val=%b ack=%b want 1 0001", dval, ack); end
        req = 4'b0;
    endtask

    task automatic test_random();
        logic [3:0]  prev_req;
        logic [63:0] prev_data;
        logic [15:0] prev_mod;
        int m_last, issues, last_issue, exp, bz_delay, bz_len;
        do_reset();
        m_last = 3; issues = 0; last_issue = -100; bz_delay = 0; bz_len = 0;
        prev_req = req; prev_data = req_data; prev_mod = req_mod;
        for (int cyc = 0; cyc < 3000 && issues < 40; cyc++) begin
            step();
            exp = -1;
            if (dval) begin
                exp = model_pick(prev_req, m_last);
                checks++; if (exp < 0) begin errors++; $display("FAIL rnd_spurious: issue with req=%b", prev_req); exp = 0; end
                checks++; if (ack !== (4'b1 << exp) || grant !== 2'(exp)) begin
                    errors++; $display("FAIL rnd_grant: ack=%b grant=%0d want winner %0d (req=%b last=%0d)", ack, grant, exp, prev_req, m_last);
                end
                checks++; if (dout !== prev_data[exp*16 +: 16] || dmod !== prev_mod[exp*4 +: 4]) begin
                    errors++; $display("FAIL rnd_data: data=%h mod=%h want %h %h", dout, dmod, prev_data[exp*16 +: 16], prev_mod[exp*4 +: 4]);
                end
                checks++; if (cyc - last_issue < 3) begin errors++; $display("FAIL rnd_spacing: %0d cycles want >=3", cyc - last_issue); end
                m_last = exp; issues++; last_issue = cyc;
                req[exp] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    bz_delay = 0; bz_len = 0;
                end else begin
                    bz_delay = $urandom_range(0, 1); bz_len = $urandom_range(1, 3);
                end
            end else begin
                checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rnd_stray_ack: ack=%b want 0", ack); end
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && i != exp && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*16 +: 16] = 16'($urandom);
                    req_mod[i*4 +: 4]    = 4'($urandom);
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (bz_delay > 0) begin busy = 1'b0; bz_delay--; end
            else if (bz_len > 0) begin busy = 1'b1; bz_len--; end
            else busy = 1'b0;
            prev_req = req; prev_data = req_data; prev_mod = req_mod;
        end
        checks++; if (issues != 40) begin errors++; $display("FAIL rnd_count: issues=%0d want 40", issues); end
        req = 4'b0; busy = 1'b0;
    endtask

    initial begin
        srst = 1'b1; req = '0; busy = 1'b0; req_data = '0; req_mod = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_hold_data();
        test_busy_block();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ser_arb.md
SER_ARB -- requirements
Module: ser_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TO, default 4, meaning max cycles to wait for serializer busy after issue.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port srst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_i  input  N_REQ  per-requester request, held until ack.
REQ-006 SHALL have port req_data_i  input  N_REQ x 16  per-requester parallel word.
REQ-007 SHALL have port req_mod_i  input  N_REQ x 4  per-requester valid-bit count, passed through unmodified.
REQ-008 SHALL have port ack_o  output  N_REQ  one-cycle one-hot acceptance pulse.
REQ-009 SHALL have port data_o  output  16  word to serializer.
REQ-010 SHALL have port data_mod_o  output  4  bit count to serializer.
REQ-011 SHALL have port data_val_o  output  1  one-cycle issue strobe to serializer.
REQ-012 SHALL have port busy_i  input  1  serializer busy.
REQ-013 SHALL have port grant_id_o  output  $clog2(N_REQ)  index of current/last granted requester.
REQ-014 SHALL have port arb_busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: if any req_i high and busy_i low, SHALL select winner and go to ISSUE next cycle; else stay.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ, wraps, first set req_i wins.
REQ-018 After reset last_grant SHALL be N_REQ-1 so requester 0 has first priority.
REQ-019 Winner's req_data_i/req_mod_i SHALL be registered on the IDLE->ISSUE transition; later input changes do not affect the issued word.
REQ-020 ISSUE (exactly 1 cycle): data_val_o=1, ack_o[winner]=1, last_grant<=winner, grant_id_o=winner; then go to WAIT_BUSY.
REQ-021 data_o/data_mod_o SHALL hold the registered word from ISSUE until the next ISSUE.
REQ-022 WAIT_BUSY: on busy_i=1 go to WAIT_DONE; if busy_i stays 0 for BUSY_TO cycles (serializer rejected word) return to IDLE.
REQ-023 WAIT_DONE: stay while busy_i=1; on busy_i=0 go to IDLE.
REQ-024 Issue-to-issue minimum spacing SHALL be 3 cycles (ISSUE, WAIT_BUSY, IDLE) even on timeout.
REQ-025 A requester deasserting req_i before ack SHALL simply lose its turn; no ack issued to a requester whose req_i was low at selection.
REQ-026 Requester SHALL drop req_i the cycle after ack or it is treated as a new request.
REQ-027 Simultaneous requests SHALL never produce more than one ack_o bit or more than one data_val_o per issue.
REQ-028 busy_i=1 while in IDLE SHALL block new grants.

Reset
REQ-029 srst_i SHALL return FSM to IDLE from any state, including mid-transfer.
REQ-030 Reset values: ack_o=0, data_val_o=0, data_o=0, data_mod_o=0, grant_id_o=0, arb_busy_o=0, timeout counter=0, last_grant=N_REQ-1.
REQ-031 During srst_i no ack_o or data_val_o SHALL assert.

Structure
REQ-032 State enum and 16/4-bit width constants SHALL live in shared package ser_pkg.
REQ-033 Round-robin selection SHALL be sub-module rr_pick (req vector + last index in, winner index + valid out, combinational).
REQ-034 ser_arb SHALL be wrapped with serializer in a top containing I/O registers for timing measurement.

Verification
REQ-035 Single req_i[2]=1, data 16'hA5C3, mod 0 -> ack_o[2] one pulse, data_val_o pulse with data_o=16'hA5C3, grant_id_o=2.
REQ-036 All four req_i held high continuously -> grant order 0,1,2,3,0 with each grant after busy_i falls.
REQ-037 busy_i never rises after issue (mod 1) -> return to IDLE after BUSY_TO=4 cycles, next requester served.
REQ-038 srst_i asserted in WAIT_DONE -> next cycle IDLE, all outputs 0, next grant goes to requester 0.
REQ-039 req_i[1] changes req_data_i from 16'h1111 to 16'h2222 during WAIT_DONE -> data_o remains 16'h1111.
REQ-040 busy_i=1 in IDLE with req_i[0]=1 -> no ack until busy_i=0, then ISSUE the following cycle.
